serial_adder_ctrl: RTL and testbench

Bit-serial multi-bit adder controller. It sequences a single one-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)) over WIDTH clock cycles, LSB first, holding the inter-bit carry in a register. It is the sequencing layer that turns the team's one-bit full-adder datapath into a WIDTH-bit adder with a start/done handshake. It trades area (one adder cell) for latency (WIDTH cycles).

---
 rtl/serial_adder_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full-adder cell over WIDTH cycles, LSB first, for a WIDTH-bit add.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one add per WIDTH+1 cycles sustained.
// Backpressure: start is sampled only in IDLE; requests during RUN are dropped, never queued.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start, a, b, cin  request and operands, captured on the accepting edge
//   busy              high while bits are being processed (state RUN)
//   done              one-cycle pulse; sum/cout update on the same edge
//   sum, cout         result of the last completed addition
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    // The single one-bit full-adder cell, fed from the LSBs of the operand
    // shift registers and the inter-bit carry.
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sr_shift;
    logic             cnt_last;

    assign fa_s     = sa_q[0] ^ sb_q[0] ^ c_q;
    assign fa_c     = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
    // Result register fills from the top so that after WIDTH shifts bit 0
    // of the sum has landed in sr[0].
    assign sr_shift = {fa_s, sr_q[WIDTH-1:1]};
    assign cnt_last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = cin;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_shift;
                c_d   = fa_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_last) begin
                    // Publish straight from the shift value so this edge's
                    // sum bit is already in the MSB of the result.
                    sum_d   = sr_shift;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start2;
    logic [1:0] a2, b2;
    logic       cin2;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit addition from IDLE with hand-computed expected results;
    // hold_sum/hold_cout is the previous result that must persist mid-run.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                           input logic [7:0] exp_sum, input logic exp_cout,
                           input logic [7:0] hold_sum, input logic hold_cout,
                           input string tag);
        int n;
        int busy_n;
        a = ta; b = tbv; cin = tc; start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
        busy_n = 1;
        n = 0;
        while (!done && n < 20) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            if (n == 4) begin
                chk({tag, "_hold_sum"}, 64'(sum), 64'(hold_sum));
                chk({tag, "_hold_cout"}, 64'(cout), 64'(hold_cout));
            end
            tick;
            n++;
            if (busy) busy_n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd8);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
        chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        tick;
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int dones;
        logic [8:0] exp9;
        logic [2:0] exp3;

        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

        // Reset dominates a held start.
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_sum", 64'(sum), 64'h00);
            chk("rst_cout", 64'(cout), 64'd0);
        end
        rst_n = 1'b1;

        // First edge out of reset accepts the held start.
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, "ff_01");
        run_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, "a5_5a");
        run_add(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 8'h00, 1'b1, "3c_42");

        // start pulsed during the third RUN cycle is ignored.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick;                               // E0
        start = 1'b0;
        tick; tick;                         // E1, E2
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        tick;                               // E3
        start = 1'b0;
        n = 3;
        while (!done && n < 20) begin
            tick;
            n++;
        end
        chk("ign_latency", 64'(n), 64'd8);
        chk("ign_sum", 64'(sum), 64'h46);
        chk("ign_cout", 64'(cout), 64'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done) dones++;
        end
        chk("ign_single_done", 64'(dones), 64'd0);
        chk("ign_idle", 64'(busy), 64'd0);

        // Reset in the 5th RUN cycle discards the addition.
        a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
        tick;                               // E0
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick;   // E1..E4
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_sum", 64'(sum), 64'h00);
        chk("mid_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done) dones++;
        end
        chk("mid_no_done", 64'(dones), 64'd0);
        run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, "80_80");

        // start held high, operands changing every cycle.
        start = 1'b1;
        exp9 = '0;
        for (int j = 0; j < 45; j++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            if (j % 9 == 0) exp9 = {1'b0, a} + {1'b0, b} + 9'(cin);
            tick;
            if (j % 9 == 8) begin
                chk("cont_done", 64'(done), 64'd1);
                chk("cont_result", 64'({cout, sum}), 64'(exp9));
            end else begin
                chk("cont_nodone", 64'(done), 64'd0);
            end
        end
        start = 1'b0;
        tick;

        // Exhaustive at WIDTH=2.
        for (int i = 0; i < 32; i++) begin
            a2 = i[1:0]; b2 = i[3:2]; cin2 = i[4];
            exp3 = {1'b0, a2} + {1'b0, b2} + 3'(cin2);
            start2 = 1'b1;
            tick;
            start2 = 1'b0;
            a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
            n = 0;
            while (!done2 && n < 6) begin
                tick;
                n++;
            end
            chk("w2_latency", 64'(n), 64'd2);
            chk("w2_result", 64'({cout2, sum2}), 64'(exp3));
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
